// File: rtl/vp415_video_pkg.sv
// Shared types and default line timing for the VP415 RGB capture path.
package vp415_video_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        ACTIVE     = 2'd2
    } line_state_e;

    localparam int          DEF_H_START      = 1134;
    localparam int          DEF_H_PIXELS     = 640;
    localparam logic [31:0] DEF_PHASE_INC    = 32'd848388602;
    localparam int          DEF_LINE_TIMEOUT = 6000;

    // Width of the line, pixel and timeout counters; all defaults fit comfortably.
    localparam int CNT_W = 16;

endpackage

// File: rtl/sync_filter.sv
// Multi-flop synchroniser for one asynchronous bit, with an optional run-length
// glitch filter (FILTER_LEN = 0 bypasses the filter).
module sync_filter #(
    parameter int STAGES     = 2,
    parameter int FILTER_LEN = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign q_o = sync_q[STAGES-1];
        end else begin : g_filter
            localparam int CW = $clog2(FILTER_LEN + 1);

            logic [CW-1:0] run_q, run_d;
            logic          filt_q, filt_d;

            // Count consecutive samples that disagree with the accepted level.
            always_comb begin
                run_d  = '0;
                filt_d = filt_q;
                if (sync_q[STAGES-1] != filt_q) begin
                    if (run_q == CW'(FILTER_LEN - 1)) begin
                        filt_d = sync_q[STAGES-1];
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    run_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    run_q  <= run_d;
                    filt_q <= filt_d;
                end
            end

            assign q_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/rgb111_sampler.sv
// BBC Micro RGB111 pixel sampler: finds hsync in composite sync, waits out the
// back porch, then samples RGB with an NCO-driven pixel clock.
module rgb111_sampler
    import vp415_video_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter int          CSYNC_FILTER = 3,
    parameter int          H_START      = DEF_H_START,
    parameter int          H_PIXELS     = DEF_H_PIXELS,
    parameter logic [31:0] PHASE_INC    = DEF_PHASE_INC,
    parameter int          LINE_TIMEOUT = DEF_LINE_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic red_in,
    input  logic green_in,
    input  logic blue_in,
    input  logic csync_in,
    output logic red_out,
    output logic green_out,
    output logic blue_out,
    output logic pixel_valid,
    output logic line_start,
    output logic sync_lost
);

    logic [2:0] rgb_in;
    logic [2:0] rgb_sync;
    logic       csync_filt;

    assign rgb_in = {red_in, green_in, blue_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rgb_sync
            sync_filter #(
                .STAGES     (SYNC_STAGES),
                .FILTER_LEN (0)
            ) u_sync (
                .clk   (clk),
                .reset (reset),
                .d_i   (rgb_in[gi]),
                .q_o   (rgb_sync[gi])
            );
        end
    endgenerate

    sync_filter #(
        .STAGES     (SYNC_STAGES),
        .FILTER_LEN (CSYNC_FILTER)
    ) u_csync (
        .clk   (clk),
        .reset (reset),
        .d_i   (csync_in),
        .q_o   (csync_filt)
    );

    line_state_e      state_q, state_d;
    logic             csync_prev_q;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      acc_sum;
    logic             carry;
    logic [2:0]       rgb_q, rgb_d;
    logic             pv_q, pv_d;
    logic             ls_q, ls_d;
    logic             lost_q, lost_d;
    logic             hsync_edge;

    assign hsync_edge     = csync_prev_q & ~csync_filt;
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, PHASE_INC};

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pix_d   = pix_q;
        acc_d   = acc_q;
        rgb_d   = rgb_q;
        pv_d    = 1'b0;
        ls_d    = hsync_edge;
        tmo_d   = (tmo_q == CNT_W'(LINE_TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
        lost_d  = lost_q || (tmo_d == CNT_W'(LINE_TIMEOUT));

        // An hsync edge restarts the line from any state and beats a coincident carry.
        if (hsync_edge) begin
            state_d = WAIT_START;
            cyc_d   = '0;
            pix_d   = '0;
            acc_d   = '0;
            tmo_d   = '0;
            lost_d  = 1'b0;
        end else if (lost_d) begin
            state_d = IDLE;
            cyc_d   = '0;
            pix_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                WAIT_START: begin
                    cyc_d = cyc_q + 1'b1;
                    if (cyc_d == CNT_W'(H_START - 1)) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    acc_d = acc_sum;
                    if (carry) begin
                        pv_d  = 1'b1;
                        rgb_d = rgb_sync;
                        pix_d = pix_q + 1'b1;
                        if (pix_q == CNT_W'(H_PIXELS - 1)) begin
                            state_d = IDLE;
                            pix_d   = '0;
                            acc_d   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Outside the active window the pixel outputs rest at black.
        if (!pv_d && state_d != ACTIVE) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            csync_prev_q <= 1'b0;
            cyc_q        <= '0;
            pix_q        <= '0;
            tmo_q        <= '0;
            acc_q        <= '0;
            rgb_q        <= '0;
            pv_q         <= 1'b0;
            ls_q         <= 1'b0;
            lost_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            csync_prev_q <= csync_filt;
            cyc_q        <= cyc_d;
            pix_q        <= pix_d;
            tmo_q        <= tmo_d;
            acc_q        <= acc_d;
            rgb_q        <= rgb_d;
            pv_q         <= pv_d;
            ls_q         <= ls_d;
            lost_q       <= lost_d;
        end
    end

    assign {red_out, green_out, blue_out} = rgb_q;
    assign pixel_valid = pv_q;
    assign line_start  = ls_q;
    assign sync_lost   = lost_q;

endmodule

// File: tb/tb_rgb111_sampler.sv
// Scoreboard bench for rgb111_sampler: stimulus predicts line_start/strobe cycles
// from the timing rules; a negedge monitor compares every cycle.
module tb_rgb111_sampler;

    localparam int          S   = 2;
    localparam int          F   = 3;
    localparam int          HS  = 10;
    localparam int          HP  = 4;
    localparam int          LT  = 6000;
    localparam logic [31:0] INC = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0, csync_in = 1'b1;
    logic red_out, green_out, blue_out, pixel_valid, line_start, sync_lost;

    rgb111_sampler #(
        .SYNC_STAGES  (S),
        .CSYNC_FILTER (F),
        .H_START      (HS),
        .H_PIXELS     (HP),
        .PHASE_INC    (INC),
        .LINE_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .csync_in    (csync_in),
        .red_out     (red_out),
        .green_out   (green_out),
        .blue_out    (blue_out),
        .pixel_valid (pixel_valid),
        .line_start  (line_start),
        .sync_lost   (sync_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit last;
    } strobe_t;

    strobe_t    sq[$];      // expected strobe cycles
    int         eq[$];      // expected filtered-fall cycles
    logic [2:0] hist [0:32767];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       rst_s = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    // Record what the driver presented during each cycle.
    always @(negedge clk) begin
        hist[cyc] = {red_in, green_in, blue_in};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // A filtered fall at t0 aborts later strobes and schedules a new line.
    task automatic add_edge(input int t0);
        longint num;
        int     m;
        eq.push_back(t0);
        while (sq.size() > 0 && sq[$].cyc > t0) void'(sq.pop_back());
        for (int k = 1; k <= HP; k++) begin
            num = longint'(k) << 32;
            m   = int'((num + longint'(INC) - 1) / longint'(INC));
            sq.push_back('{cyc: t0 + HS + m, last: (k == HP)});
        end
    endtask

    task automatic tick(input logic cs, input logic [2:0] rgb, input bit mark);
        @(posedge clk);
        #1;
        csync_in = cs;
        {red_in, green_in, blue_in} = rgb;
        if (mark) add_edge(cyc + S + F);
    endtask

    task automatic pulse(input int low, input int high, input bit hold);
        for (int i = 0; i < low + high; i++) begin
            tick(i >= low, hold ? 3'b101 : 3'($urandom), (i == 0) && (low >= F));
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        while (sq.size() > 0 && sq[$].cyc > cyc) void'(sq.pop_back());
        while (eq.size() > 0 && eq[$] + 1 > cyc) void'(eq.pop_back());
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [2:0] exp_rgb = 3'b000;
    bit         clr_next = 1'b0;
    bit         seen = 1'b0;
    int         last_edge = 0;

    always @(negedge clk) begin
        bit exp_pv;
        bit exp_ls;
        if (rst_s) begin
            seen     = 1'b0;
            exp_rgb  = 3'b000;
            clr_next = 1'b0;
            check("rst_pixel_valid", pixel_valid, 0);
            check("rst_line_start", line_start, 0);
            check("rst_rgb", {red_out, green_out, blue_out}, 0);
            check("rst_sync_lost", sync_lost, 1);
        end else begin
            while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
            while (eq.size() > 0 && eq[0] + 1 < cyc) void'(eq.pop_front());
            exp_ls = (eq.size() > 0 && eq[0] + 1 == cyc);
            if (exp_ls) begin
                last_edge = eq.pop_front();
                seen      = 1'b1;
            end
            exp_pv = (sq.size() > 0 && sq[0].cyc == cyc);
            if (exp_ls || clr_next) exp_rgb = 3'b000;
            clr_next = 1'b0;
            if (exp_pv) begin
                exp_rgb  = hist[cyc-S-1];
                clr_next = sq[0].last;
                void'(sq.pop_front());
            end
            check("line_start", line_start, exp_ls);
            check("pixel_valid", pixel_valid, exp_pv);
            check("rgb", {red_out, green_out, blue_out}, exp_rgb);
            check("sync_lost", sync_lost, (!seen || cyc >= last_edge + 1 + LT));
            if (line_start) $display("line_start cyc=%0d", cyc);
            if (pixel_valid) $display("pixel cyc=%0d rgb=%03b", cyc, {red_out, green_out, blue_out});
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        pulse(0, 12, 0);
        pulse(4, 40, 1);        // steady 101 through the window
        pulse(2, 40, 0);        // sub-filter glitches
        pulse(1, 30, 0);
        pulse(4, 15, 0);        // second edge lands after two strobes
        pulse(5, 50, 0);
        for (int n = 0; n < 20; n++) begin
            pulse(int'($urandom_range(6, 1)), int'($urandom_range(60, 20)), 0);
        end
        pulse(0, 6100, 0);      // long silence
        pulse(4, 40, 0);
        pulse(4, 16, 0);        // reset lands mid-window
        do_reset(2);
        pulse(0, 12, 0);
        pulse(4, 40, 0);
        check("strobes_pending", sq.size(), 0);
        check("edges_pending", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
